// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional stall counter port is enabled by defining IF_ID_STALL_CNT_EN.
module if_id_skid_stage #(
    parameter int                 INSTR_W      = 32,
    parameter int                 PC_W         = 32,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = BUBBLE_INSTR;
            main_pc_d    = '0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end
                end
                ST_ONE: begin
                    unique case ({in_fire, out_fire})
                        2'b11: begin
                            main_instr_d = in_instr;
                            main_pc_d    = in_pc;
                        end
                        2'b10: begin
                            state_d      = ST_FULL;
                            skid_instr_d = in_instr;
                            skid_pc_d    = in_pc;
                        end
                        2'b01: begin
                            state_d      = ST_EMPTY;
                            main_instr_d = BUBBLE_INSTR;
                            main_pc_d    = '0;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists
                    if (out_fire) begin
                        state_d      = ST_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        skid_instr_d = '0;
                        skid_pc_d    = '0;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_instr_d = BUBBLE_INSTR;
                    main_pc_d    = '0;
                    skid_instr_d = '0;
                    skid_pc_d    = '0;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= BUBBLE_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating; flush leaves it alone so stalls survive redirects
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: queue model checked every cycle plus directed literals.
// Stall counter checks run only when IF_ID_STALL_CNT_EN is defined.
module tb_if_id_skid_stage;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [31:0] BUB = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_id_skid_stage #(
        .INSTR_W(INSTR_W),
        .PC_W(PC_W),
        .BUBBLE_INSTR(BUB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the stage is a 2-deep FIFO; head is what decode sees.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    bit   model_ok = 0;

    always @(posedge clk) begin
        bit ir;
        bit ov;
        if (reset) begin
            q.delete();
            model_ok = 1;
        end else if (model_ok) begin
            ir = (q.size() < 2);
            ov = (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (ov && out_ready) void'(q.pop_front());
                if (in_valid && ir) q.push_back('{in_instr, in_pc});
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("m_out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
            check("m_in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
            if (q.size() > 0) begin
                check("m_out_instr", {32'b0, out_instr}, {32'b0, q[0].instr});
                check("m_out_pc", {32'b0, out_pc}, {32'b0, q[0].pc});
            end else begin
                check("m_bub_instr", {32'b0, out_instr}, {32'b0, BUB});
                check("m_bub_pc", {32'b0, out_pc}, 64'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = p;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_instr = '0;
        in_pc    = '0;
    endtask

    task automatic lit(input string n, input logic v, input logic r,
                       input logic [31:0] i, input logic [31:0] p);
        check({n, "_valid"}, {63'b0, out_valid}, {63'b0, v});
        check({n, "_ready"}, {63'b0, in_ready}, {63'b0, r});
        check({n, "_instr"}, {32'b0, out_instr}, {32'b0, i});
        check({n, "_pc"}, {32'b0, out_pc}, {32'b0, p});
    endtask

    logic [63:0] vpat;
    logic [63:0] rpat;

    initial begin
        // reset with a valid instruction on the input that must be ignored
        reset = 1'b1;
        push(32'h2008_0005, 32'h40);
        tick();
        tick();
        lit("rst", 1'b0, 1'b1, 32'h0, 32'h0);
        reset = 1'b0;
        idle_in();
        tick();
        lit("post_rst", 1'b0, 1'b1, 32'h0, 32'h0);

        // streaming
        out_ready = 1'b1;
        push(32'h2008_0001, 32'h0);
        tick();
        lit("s0", 1'b1, 1'b1, 32'h2008_0001, 32'h0);
        push(32'h2008_0002, 32'h4);
        tick();
        lit("s1", 1'b1, 1'b1, 32'h2008_0002, 32'h4);
        push(32'h2008_0003, 32'h8);
        tick();
        lit("s2", 1'b1, 1'b1, 32'h2008_0003, 32'h8);
        idle_in();
        tick();
        lit("s_end", 1'b0, 1'b1, 32'h0, 32'h0);

        // backpressure into the skid slot
        out_ready = 1'b0;
        push(32'h2008_000A, 32'h0);
        tick();
        lit("bp0", 1'b1, 1'b1, 32'h2008_000A, 32'h0);
        push(32'h2008_000B, 32'h4);
        tick();
        lit("bp_full", 1'b1, 1'b0, 32'h2008_000A, 32'h0);
        idle_in();
        tick();
        lit("bp_hold", 1'b1, 1'b0, 32'h2008_000A, 32'h0);
        out_ready = 1'b1;
        tick();
        lit("bp_drain1", 1'b1, 1'b1, 32'h2008_000B, 32'h4);
        tick();
        lit("bp_drain2", 1'b0, 1'b1, 32'h0, 32'h0);

        // flush while full, with an input offered in the flush cycle
        out_ready = 1'b0;
        push(32'h2008_0010, 32'h10);
        tick();
        push(32'h2008_0014, 32'h14);
        tick();
        lit("f_full", 1'b1, 1'b0, 32'h2008_0010, 32'h10);
        flush = 1'b1;
        push(32'h2008_0018, 32'h18);
        tick();
        lit("f_after", 1'b0, 1'b1, BUB, 32'h0);
        flush = 1'b0;
        idle_in();
        out_ready = 1'b1;
        tick();
        lit("f_quiet", 1'b0, 1'b1, BUB, 32'h0);

        // single-entry drain
        push(32'h2008_0020, 32'h20);
        tick();
        lit("d0", 1'b1, 1'b1, 32'h2008_0020, 32'h20);
        idle_in();
        tick();
        lit("d1", 1'b0, 1'b1, 32'h0, 32'h0);

        // mixed valid/ready pattern, checked by the model each cycle
        vpat = 64'hB6D5_A3FE_91C7_7E2D;
        rpat = 64'h5A3C_96E1_F00F_C3A5;
        for (int i = 0; i < 64; i++) begin
            in_valid  = vpat[i];
            in_instr  = 32'h3000_0000 + i;
            in_pc     = 32'h100 + 4 * i;
            out_ready = rpat[i];
            flush     = (i == 30) || (i == 47);
            tick();
        end
        flush = 1'b0;
        idle_in();
        out_ready = 1'b1;
        tick();
        tick();
        lit("mix_end", 1'b0, 1'b1, 32'h0, 32'h0);

`ifdef IF_ID_STALL_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_rst", {32'b0, stall_cycles}, 64'd0);
        out_ready = 1'b0;
        push(32'h2008_0030, 32'h30);
        tick();
        idle_in();
        for (int i = 0; i < 7; i++) tick();
        check("cnt_7", {32'b0, stall_cycles}, 64'd7);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_flush", {32'b0, stall_cycles}, 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_clr", {32'b0, stall_cycles}, 64'd0);
        out_ready = 1'b0;
        push(32'h2008_0034, 32'h34);
        tick();
        idle_in();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        for (int i = 0; i < 3; i++) tick();
        check("cnt_sat", {32'b0, stall_cycles}, 64'hFFFF_FFFF);
        out_ready = 1'b1;
        tick();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
